// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: feeds evenly spaced frames of a recording to an FFT and reports each frame's peak bin
module fft_frame_scheduler #(
  parameter int SAMPLES_PER_FRAME = 1024,
  parameter int NUM_FRAMES = 4,
  parameter int BIN_W = 10
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic [31:0]             recording_length_in,
  input  logic                    sample_valid_in,
  input  logic signed [15:0]      sample_in,
  output logic                    fft_in_valid_out,
  output logic                    fft_in_last_out,
  output logic signed [15:0]      fft_in_data_out,
  input  logic                    fft_in_ready_in,
  input  logic                    fft_out_valid_in,
  input  logic                    fft_out_last_in,
  input  logic [31:0]             fft_out_mag_in,
  output logic [BIN_W-1:0]        peak_bin_out,
  output logic [31:0]             peak_mag_out,
  output logic                    peak_valid_out,
  input  logic                    peak_ready_in,
  output logic [1:0]              frame_idx_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    overrun_out
);
  typedef enum logic [2:0] {IDLE, ARM, FEED, SCAN, REPORT, GAP, DONE} state_t;
  state_t state;
  logic [31:0] slot_period, slot_timer;
  logic [BIN_W-1:0] sample_cnt, bin_cnt;
  logic xfer, slot_end;
  assign xfer = state == REPORT && peak_ready_in;
  assign slot_end = slot_timer >= slot_period - 32'd1;
  assign fft_in_valid_out = state == FEED && sample_valid_in;
  assign fft_in_last_out = fft_in_valid_out && sample_cnt == BIN_W'(SAMPLES_PER_FRAME - 1);
  assign fft_in_data_out = state == FEED ? sample_in : '0;
  assign peak_valid_out = state == REPORT;
  assign busy_out = state != IDLE;
  assign done_out = state == DONE;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      slot_period <= '0;
      slot_timer <= '0;
      sample_cnt <= '0;
      bin_cnt <= '0;
      peak_bin_out <= '0;
      peak_mag_out <= '0;
      frame_idx_out <= '0;
      overrun_out <= 1'b0;
    end else begin
      if (state inside {FEED, SCAN, REPORT, GAP}) slot_timer <= slot_timer + 32'd1;
      if (state inside {FEED, SCAN, REPORT} && slot_end && !xfer) overrun_out <= 1'b1;
      case (state)
        IDLE: if (start_in) begin
          slot_period <= recording_length_in >> $clog2(NUM_FRAMES);
          overrun_out <= 1'b0;
          frame_idx_out <= '0;
          state <= ARM;
        end
        ARM: if (slot_period < 32'(SAMPLES_PER_FRAME)) begin
          overrun_out <= 1'b1;
          state <= DONE;
        end else begin
          slot_timer <= '0;
          sample_cnt <= '0;
          state <= FEED;
        end
        FEED: if (sample_valid_in && !fft_in_ready_in) overrun_out <= 1'b1;
        else if (sample_valid_in) begin
          sample_cnt <= sample_cnt + BIN_W'(1);
          if (fft_in_last_out) begin
            bin_cnt <= '0;
            peak_bin_out <= BIN_W'(1);
            peak_mag_out <= '0;
            state <= SCAN;
          end
        end
        SCAN: if (fft_out_valid_in) begin
          bin_cnt <= bin_cnt + BIN_W'(1);
          if (bin_cnt != '0 && fft_out_mag_in > peak_mag_out) begin
            peak_bin_out <= bin_cnt;
            peak_mag_out <= fft_out_mag_in;
          end
          if (fft_out_last_in) state <= REPORT;
        end
        REPORT: if (peak_ready_in) begin
          if (frame_idx_out == 2'(NUM_FRAMES - 1)) state <= DONE;
          else begin
            frame_idx_out <= frame_idx_out + 2'd1;
            if (slot_end) slot_timer <= '0;
            state <= slot_end ? FEED : GAP;
          end
        end
        GAP: if (slot_end) begin
          slot_timer <= '0;
          state <= FEED;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: directed self-checking bench for fft_frame_scheduler with an 8-sample frame
module tb_fft_frame_scheduler;
  logic clk_in = 1'b0;
  logic rst_n_in, start_in, sample_valid_in, fft_in_ready_in;
  logic fft_out_valid_in, fft_out_last_in, peak_ready_in;
  logic [31:0] recording_length_in, fft_out_mag_in;
  logic signed [15:0] sample_in, fft_in_data_out;
  logic fft_in_valid_out, fft_in_last_out, peak_valid_out, busy_out, done_out, overrun_out;
  logic [2:0] peak_bin_out;
  logic [31:0] peak_mag_out;
  logic [1:0] frame_idx_out;
  logic [31:0] mags [8];
  int errors = 0, checks = 0, cyc = 0, done_cnt = 0, beats = 0;
  int feed_t [$];
  logic fv_q = 1'b0;
  fft_frame_scheduler #(.SAMPLES_PER_FRAME(8), .NUM_FRAMES(4), .BIN_W(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .recording_length_in(recording_length_in), .sample_valid_in(sample_valid_in),
    .sample_in(sample_in), .fft_in_valid_out(fft_in_valid_out),
    .fft_in_last_out(fft_in_last_out), .fft_in_data_out(fft_in_data_out),
    .fft_in_ready_in(fft_in_ready_in), .fft_out_valid_in(fft_out_valid_in),
    .fft_out_last_in(fft_out_last_in), .fft_out_mag_in(fft_out_mag_in),
    .peak_bin_out(peak_bin_out), .peak_mag_out(peak_mag_out),
    .peak_valid_out(peak_valid_out), .peak_ready_in(peak_ready_in),
    .frame_idx_out(frame_idx_out), .busy_out(busy_out), .done_out(done_out),
    .overrun_out(overrun_out)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) begin
    fv_q <= fft_in_valid_out;
    if (fft_in_valid_out && !fv_q) feed_t.push_back(cyc);
    if (done_out) done_cnt <= done_cnt + 1;
    if (fft_in_valid_out && fft_in_ready_in) beats <= beats + 1;
  end
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_for_last();
    int n = 0;
    while (!fft_in_last_out && n < 60) begin
      tick();
      n++;
    end
    chk("wait_last", fft_in_last_out, 1);
    chk("feed_data", fft_in_data_out, sample_in);
    tick();
  endtask
  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      fft_out_valid_in = 1'b1;
      fft_out_mag_in = mags[i];
      fft_out_last_in = i == n - 1;
      tick();
    end
    fft_out_valid_in = 1'b0;
    fft_out_last_in = 1'b0;
  endtask
  initial begin
    int d0, b0, f0, acc, n;
    rst_n_in = 1'b0;
    start_in = 1'b0;
    recording_length_in = '0;
    sample_valid_in = 1'b0;
    sample_in = 16'sh1234;
    fft_in_ready_in = 1'b1;
    fft_out_valid_in = 1'b0;
    fft_out_last_in = 1'b0;
    fft_out_mag_in = '0;
    peak_ready_in = 1'b1;
    repeat (2) tick();
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_ovr", overrun_out, 0);
    chk("rst_pvalid", peak_valid_out, 0);
    chk("rst_idx", frame_idx_out, 0);
    chk("rst_fvalid", fft_in_valid_out, 0);
    chk("rst_data", fft_in_data_out, 0);
    rst_n_in = 1'b1;
    tick();
    sample_valid_in = 1'b1;
    recording_length_in = 16;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("short_arm_busy", busy_out, 1);
    chk("short_arm_done", done_out, 0);
    tick();
    chk("short_done", done_out, 1);
    chk("short_ovr", overrun_out, 1);
    tick();
    chk("short_done_drop", done_out, 0);
    chk("short_idle", busy_out, 0);
    chk("short_ovr_sticky", overrun_out, 1);
    chk("short_done_cnt", done_cnt, 1);
    chk("short_no_beats", beats, 0);
    recording_length_in = 128;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("start_clr_ovr", overrun_out, 0);
    wait_for_last();
    chk("scan_no_valid", fft_in_valid_out, 0);
    chk("scan_no_last", fft_in_last_out, 0);
    mags = '{100, 5, 7, 7, 1, 0, 0, 0};
    scan(8);
    chk("tie_pvalid", peak_valid_out, 1);
    chk("tie_bin", peak_bin_out, 2);
    chk("tie_mag", peak_mag_out, 7);
    chk("tie_idx", frame_idx_out, 0);
    tick();
    chk("tie_drop", peak_valid_out, 0);
    chk("tie_ovr", overrun_out, 0);
    chk("tie_idx_inc", frame_idx_out, 1);
    peak_ready_in = 1'b0;
    wait_for_last();
    mags = '{0, 0, 0, 0, 0, 0, 0, 0};
    scan(5);
    repeat (10) tick();
    chk("late_ovr_early", overrun_out, 0);
    chk("late_hold", peak_valid_out, 1);
    repeat (10) tick();
    chk("late_ovr", overrun_out, 1);
    chk("late_pvalid", peak_valid_out, 1);
    chk("zero_bin", peak_bin_out, 1);
    chk("zero_mag", peak_mag_out, 0);
    chk("late_idx", frame_idx_out, 1);
    peak_ready_in = 1'b1;
    tick();
    chk("late_next_feed", fft_in_valid_out, 1);
    chk("late_drop", peak_valid_out, 0);
    chk("late_idx_inc", frame_idx_out, 2);
    wait_for_last();
    fft_out_valid_in = 1'b1;
    fft_out_mag_in = 40;
    repeat (2) tick();
    fft_out_valid_in = 1'b0;
    chk("pre_rst_mag", peak_mag_out, 40);
    d0 = done_cnt;
    #2 rst_n_in = 1'b0;
    #1;
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_idx", frame_idx_out, 0);
    chk("mid_rst_ovr", overrun_out, 0);
    chk("mid_rst_bin", peak_bin_out, 0);
    chk("mid_rst_mag", peak_mag_out, 0);
    chk("mid_rst_fvalid", fft_in_valid_out, 0);
    repeat (3) tick();
    chk("mid_rst_no_done", done_cnt, d0);
    rst_n_in = 1'b1;
    recording_length_in = 64;
    start_in = 1'b1;
    d0 = done_cnt;
    b0 = beats;
    f0 = feed_t.size();
    tick();
    start_in = 1'b0;
    chk("nom_start_busy", busy_out, 1);
    for (int f = 0; f < 4; f++) begin
      wait_for_last();
      mags = '{500, 4, 6, 32'(20 + f), 11, 0, 0, 0};
      scan(5);
      chk("nom_pvalid", peak_valid_out, 1);
      chk("nom_bin", peak_bin_out, 3);
      chk("nom_mag", peak_mag_out, 32'(20 + f));
      chk("nom_idx", frame_idx_out, 32'(f));
      tick();
    end
    chk("nom_done", done_out, 1);
    tick();
    chk("nom_done_drop", done_out, 0);
    chk("nom_idle", busy_out, 0);
    chk("nom_ovr", overrun_out, 0);
    chk("nom_done_cnt", done_cnt - d0, 1);
    chk("nom_beats", beats - b0, 32);
    chk("nom_feeds", feed_t.size() - f0, 4);
    if (feed_t.size() - f0 == 4)
      for (int i = f0 + 1; i < f0 + 4; i++) chk("nom_spacing", feed_t[i] - feed_t[i-1], 16);
    recording_length_in = 128;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    b0 = beats;
    n = 0;
    while (!fft_in_valid_out && n < 10) begin
      tick();
      n++;
    end
    chk("bp_feed", fft_in_valid_out, 1);
    acc = 0;
    for (int c = 0; acc < 8 && c < 20; c++) begin
      fft_in_ready_in = !(c >= 2 && c < 5);
      #1;
      if (c == 2) chk("bp_ovr_pre", overrun_out, 0);
      if (fft_in_ready_in) begin
        acc++;
        chk("bp_last", fft_in_last_out, acc == 8);
      end
      tick();
    end
    fft_in_ready_in = 1'b1;
    chk("bp_acc", acc, 8);
    chk("bp_ovr", overrun_out, 1);
    chk("bp_beats", beats - b0, 8);
    chk("bp_scan_no_valid", fft_in_valid_out, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
